confreg_resp: RTL and testbench

- Responder for the CPU data-SRAM port, decoding the peripheral window at physical 0x1FAF_0000–0x1FAF_FFFF (post-MMU addresses).
- Holds the board-facing registers: LEDs, numeric display, switch input and a free-running timer, plus an 8-word scratch bank.
- Answers the same single-port, fixed-latency SRAM protocol the CPU core drives: en, byte write-enables, address, write data in; read data back one cycle later.
- Sits beside the data RAM; an external address split steers data_sram_en into this block.

---
 rtl/confreg_resp.sv | 152 +++++++++++++++
 tb/tb_confreg_resp.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/confreg_resp.sv
// Board-facing configuration register responder on the CPU data-SRAM port.
// Holds LED, numeric display, switch, timer/compare and an 8-word scratch bank.
module confreg_resp #(
   parameter logic [15:0] BASE_HI = 16'h1FAF,
   parameter int unsigned SW_W    = 8
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            data_sram_en,
   input  logic [3:0]      data_sram_wen,
   input  logic [31:0]     data_sram_addr,
   input  logic [31:0]     data_sram_wdata,
   output logic [31:0]     data_sram_rdata,
   input  logic [SW_W-1:0] switch,
   output logic [15:0]     led,
   output logic [31:0]     num_data,
   output logic            timer_irq
);

   localparam int unsigned DW     = 32;
   localparam int unsigned NSCR   = 8;
   localparam logic [15:0] OFF_TIMER   = 16'hE000;
   localparam logic [15:0] OFF_COMPARE = 16'hE004;
   localparam logic [15:0] OFF_LED     = 16'hF000;
   localparam logic [15:0] OFF_NUM     = 16'hF010;
   localparam logic [15:0] OFF_SWITCH  = 16'hF020;
   localparam logic [10:0] SCR_PAGE    = 11'h400;

   logic [DW-1:0]   scratch_q [NSCR];
   logic [DW-1:0]   scratch_d [NSCR];
   logic [DW-1:0]   timer_q, timer_d;
   logic [DW-1:0]   compare_q, compare_d;
   logic [15:0]     led_q, led_d;
   logic [DW-1:0]   num_q, num_d;
   logic [SW_W-1:0] sw_meta_q, sw_sync_q;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            irq_q, irq_d;

   logic        hit;
   logic        wr;
   logic        is_scr;
   logic [2:0]  scr_idx;
   logic [15:0] off;
   logic [DW-1:0] rd_val;

   // Per-lane byte merge of write data over an existing register value.
   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [3:0]  we);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i*8 +: 8] = we[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
      end
      return r;
   endfunction

   // Word offset: the two byte-select bits never distinguish registers.
   assign off     = data_sram_addr[15:0] & 16'hFFFC;
   assign hit     = data_sram_en && (data_sram_addr[31:16] == BASE_HI);
   assign wr      = hit && (data_sram_wen != 4'b0000);
   assign is_scr  = (off[15:5] == SCR_PAGE);
   assign scr_idx = off[4:2];

   // Read mux sees pre-edge register values.
   always_comb begin
      rd_val = '0;
      if (is_scr) begin
         rd_val = scratch_q[scr_idx];
      end else begin
         case (off)
            OFF_TIMER:   rd_val = timer_q;
            OFF_COMPARE: rd_val = compare_q;
            OFF_LED:     rd_val = {16'h0000, led_q};
            OFF_NUM:     rd_val = num_q;
            OFF_SWITCH:  rd_val = DW'(sw_sync_q);
            default:     rd_val = '0;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NSCR; i++) begin
         scratch_d[i] = scratch_q[i];
      end
      timer_d   = timer_q + DW'(1);
      compare_d = compare_q;
      led_d     = led_q;
      num_d     = num_q;
      rdata_d   = rdata_q;
      irq_d     = (compare_q != '0) && (timer_q == compare_q);

      if (hit && (data_sram_wen == 4'b0000)) begin
         rdata_d = rd_val;
      end

      if (wr) begin
         if (is_scr) begin
            for (int i = 0; i < NSCR; i++) begin
               if (scr_idx == 3'(i)) begin
                  scratch_d[i] = merge(scratch_q[i], data_sram_wdata, data_sram_wen);
               end
            end
         end else begin
            case (off)
               // A timer write replaces this cycle's increment.
               OFF_TIMER:   timer_d   = merge(timer_q, data_sram_wdata, data_sram_wen);
               OFF_COMPARE: compare_d = merge(compare_q, data_sram_wdata, data_sram_wen);
               OFF_LED: begin
                  if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
                  if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
               end
               OFF_NUM:     num_d     = merge(num_q, data_sram_wdata, data_sram_wen);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NSCR; i++) begin
            scratch_q[i] <= '0;
         end
         timer_q   <= '0;
         compare_q <= '0;
         led_q     <= '0;
         num_q     <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         for (int i = 0; i < NSCR; i++) begin
            scratch_q[i] <= scratch_d[i];
         end
         timer_q   <= timer_d;
         compare_q <= compare_d;
         led_q     <= led_d;
         num_q     <= num_d;
         sw_meta_q <= switch;
         sw_sync_q <= sw_meta_q;
         rdata_q   <= rdata_d;
         irq_q     <= irq_d;
      end
   end

   assign data_sram_rdata = rdata_q;
   assign led             = led_q;
   assign num_data        = num_q;
   assign timer_irq       = irq_q;

endmodule

// File: tb/tb_confreg_resp.sv
// Directed bench for confreg_resp: read expectations go through a scoreboard
// queue checked by an independent monitor; side outputs are checked inline.
module tb_confreg_resp;

   localparam logic [31:0] A_SCR1    = 32'h1FAF_8004;
   localparam logic [31:0] A_SCR2    = 32'h1FAF_8008;
   localparam logic [31:0] A_TIMER   = 32'h1FAF_E000;
   localparam logic [31:0] A_COMPARE = 32'h1FAF_E004;
   localparam logic [31:0] A_LED     = 32'h1FAF_F000;
   localparam logic [31:0] A_NUM     = 32'h1FAF_F010;
   localparam logic [31:0] A_SWITCH  = 32'h1FAF_F020;
   localparam logic [31:0] A_UNMAP   = 32'h1FAF_1234;

   logic        clk;
   logic        resetn;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [7:0]  switch;
   logic [15:0] led;
   logic [31:0] num_data;
   logic        timer_irq;

   int checks;
   int errors;
   logic rd_flag;
   logic [31:0] exp_q [$];

   confreg_resp #(.BASE_HI(16'h1FAF), .SW_W(8)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .switch          (switch),
      .led             (led),
      .num_data        (num_data),
      .timer_irq       (timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
      @(negedge clk);
      data_sram_en = 1'b1; data_sram_wen = we; data_sram_addr = a; data_sram_wdata = d;
      rd_flag = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp);
      @(negedge clk);
      data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = a; data_sram_wdata = '0;
      rd_flag = 1'b1;
      exp_q.push_back(exp);
   endtask

   task automatic idle();
      @(negedge clk);
      data_sram_en = 1'b0; data_sram_wen = 4'b0000; rd_flag = 1'b0;
   endtask

   // Monitor: a read presented at an edge must show its data just after it.
   initial begin
      logic pend;
      logic [31:0] e;
      forever begin
         @(posedge clk);
         pend = rd_flag;
         #1;
         if (pend) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", data_sram_rdata, 32'hxxxx_xxxx);
            end else begin
               e = exp_q.pop_front();
               check("rdata", data_sram_rdata, e);
            end
         end
      end
   end

   initial begin
      resetn = 1'b0; data_sram_en = 1'b0; data_sram_wen = '0;
      data_sram_addr = '0; data_sram_wdata = '0; switch = 8'hA5; rd_flag = 1'b0;
      checks = 0; errors = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_led", 32'(led), 32'h0);
      check("rst_num", num_data, 32'h0);
      check("rst_rdata", data_sram_rdata, 32'h0);
      check("rst_irq", 32'(timer_irq), 32'h0);

      @(negedge clk); resetn = 1'b1;
      @(posedge clk); @(posedge clk);
      rd(A_SWITCH, 32'h0000_00A5);
      // Pin change lands in the read value two edges later.
      switch = 8'h3C;
      rd(A_SWITCH, 32'h0000_00A5);
      rd(A_SWITCH, 32'h0000_003C);

      wr(A_SCR1, 4'b1111, 32'h1234_5678);
      wr(A_SCR1, 4'b0100, 32'h00AB_0000);
      rd(A_SCR1, 32'h12AB_5678);
      rd(A_SCR2, 32'h0000_0000);

      wr(A_LED, 4'b1111, 32'hFFFF_BEEF);
      @(posedge clk); #1;
      check("led_write", 32'(led), 32'h0000_BEEF);
      rd(A_LED, 32'h0000_BEEF);

      wr(A_TIMER, 4'b1111, 32'hFFFF_FFFE);
      rd(A_TIMER, 32'hFFFF_FFFE);
      rd(A_TIMER, 32'hFFFF_FFFF);
      rd(A_TIMER, 32'h0000_0000);

      wr(A_TIMER, 4'b1111, 32'h1000_0000);
      wr(A_COMPARE, 4'b1111, 32'h0000_0040);
      wr(A_TIMER, 4'b1111, 32'h0000_003D);
      @(posedge clk); #1;
      data_sram_en = 1'b0; data_sram_wen = '0;
      check("irq_k0", 32'(timer_irq), 32'h0);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         check($sformatf("irq_k%0d", k), 32'(timer_irq), (k == 4) ? 32'h1 : 32'h0);
      end

      wr(A_COMPARE, 4'b1111, 32'h0000_0000);
      wr(A_TIMER, 4'b1111, 32'hFFFF_FFF0);
      @(posedge clk); #1;
      data_sram_en = 1'b0; data_sram_wen = '0;
      for (int k = 0; k < 24; k++) begin
         @(posedge clk); #1;
         check("irq_disabled", 32'(timer_irq), 32'h0);
      end
      rd(A_COMPARE, 32'h0000_0000);

      wr(A_NUM, 4'b1111, 32'h0BAD_F00D);
      @(posedge clk); #1;
      check("num_write", num_data, 32'h0BAD_F00D);
      rd(A_NUM, 32'h0BAD_F00D);
      wr(A_UNMAP, 4'b1111, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      check("rdata_hold_write", data_sram_rdata, 32'h0BAD_F00D);
      rd(A_UNMAP, 32'h0000_0000);

      wr(32'h1FC0_F000, 4'b1111, 32'h0000_1111);
      wr(32'h1FC0_F010, 4'b1111, 32'h0000_2222);
      @(negedge clk);
      data_sram_wen = 4'b0000; data_sram_addr = 32'h1FC0_F000;
      @(posedge clk); #1;
      check("miss_led", 32'(led), 32'h0000_BEEF);
      check("miss_num", num_data, 32'h0BAD_F00D);
      check("miss_rdata", data_sram_rdata, 32'h0000_0000);

      rd(A_SCR1, 32'h12AB_5678);
      idle();
      #2 resetn = 1'b0;
      #1;
      check("async_rst_rdata", data_sram_rdata, 32'h0);
      check("async_rst_led", 32'(led), 32'h0);
      check("async_rst_num", num_data, 32'h0);
      @(negedge clk); resetn = 1'b1;
      rd(A_SCR1, 32'h0000_0000);
      idle();
      idle();

      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
